arb_req_client: RTL and testbench
=================================

ARB_REQ_CLIENT -- requirements
Module: arb_req_client

Interface
REQ-001 SHALL have parameter DW, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel queue (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  producer offers one entry.
REQ-006 SHALL have port wr_ch  input  2  target channel of offered entry.
REQ-007 SHALL have port wr_data  input  DW  payload of offered entry.
REQ-008 SHALL have port wr_ready  output  1  queue wr_ch not full (combinational).
REQ-009 SHALL have port req  output  4  per-channel request to the 4-way round-robin arbiter.
REQ-010 SHALL have port grant  input  4  one-hot registered grant from the arbiter (0000 = idle).
REQ-011 SHALL have port out_valid  output  1  output register holds a beat.
REQ-012 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-013 SHALL have port out_ch  output  2  channel of the held beat.
REQ-014 SHALL have port out_data  output  DW  payload of the held beat.
REQ-015 SHALL have port err  output  1  sticky protocol-error flag.
REQ-016 SHALL have port err_clr  input  1  synchronous clear of err.

Function
REQ-017 SHALL keep four independent FIFO queues of DEPTH entries, with wrapping read/write pointers and a count of 0..DEPTH.
REQ-018 SHALL push wr_data into queue wr_ch on a clock edge where wr_valid && wr_ready; a write offered to a full queue SHALL be held off (wr_ready=0), never dropped or overwritten.
REQ-019 SHALL drive req[i] = (count[i] != 0), combinationally from current counts.
REQ-020 SHALL define load_ok = !out_valid || out_ready.
REQ-021 SHALL pop queue i on an edge where grant[i] && count[i]!=0 && load_ok; out_data/out_ch SHALL load the head entry and out_valid SHALL be 1 from the next cycle.
REQ-022 A grant with load_ok=0 SHALL be ignored (no pop); req[i] stays asserted so the arbiter returns to channel i later.
REQ-023 A grant to an empty channel (arbiter one-cycle lag after the last pop) SHALL be ignored and SHALL NOT set err.
REQ-024 SHALL clear out_valid on out_ready && out_valid when no pop occurs in the same cycle; pop and drain in the same cycle SHALL replace the beat with out_valid held at 1.
REQ-025 Simultaneous push and pop on the same queue SHALL leave its count unchanged and SHALL be legal when the queue is full (wr_ready=0 still holds that write off) or empty (grant ignored).
REQ-026 SHALL set err when grant is not one-hot-or-zero, or when grant[i]=1 while req[i] was 0 in the previous cycle.
REQ-027 err SHALL stay set until an edge with err_clr=1; a new error in the same cycle as err_clr SHALL win (err stays 1).
REQ-028 Latency from push into an empty channel with an idle arbiter: req in the same cycle, grant the next cycle, out_valid the cycle after (2 edges).

Reset
REQ-029 SHALL, while rst=0, force all counts and pointers to 0, out_valid=0, out_ch=0, out_data=0, err=0, so req=0000 and wr_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries and any held beat; queue RAM contents need no reset.

Structure
REQ-031 Shared package SHALL hold NCH=4, channel-index width 2, and grant one-hot constants GNT_NONE/GNT_CH0..GNT_CH3.
REQ-032 Per-channel queue SHALL be sub-module arb_req_fifo (push, pop, data, count, full, empty), instantiated four times.

Verification
REQ-033 Bench SHALL run reset: rst=0 mid-stream with 3 entries queued -> req=0000, out_valid=0, err=0, wr_ready=1 after release.
REQ-034 Bench SHALL run a single entry: push ch2 data 0x5A with arbiter idle -> req=0100, grant=0100 next cycle, out_valid=1, out_ch=2, out_data=0x5A one edge later; req=0000.
REQ-035 Bench SHALL run round-robin: one entry each in ch0..ch3 (0x10..0x13), out_ready=1 -> beats out in order ch0,ch1,ch2,ch3, one per cycle, err=0.
REQ-036 Bench SHALL run backpressure: out_ready=0 for 5 cycles with ch1 holding 2 entries -> exactly 1 beat held, count[1]=1, no loss; release yields 2nd beat.
REQ-037 Bench SHALL run full: 4 pushes to ch3 then a 5th -> wr_ready=0 while wr_ch=3, and a simultaneous pop raises wr_ready next cycle.
REQ-038 Bench SHALL run protocol error: grant=0011, then grant=0001 with req[0] low previous cycle -> err=1, held until err_clr; trailing lag grant after the last pop -> err stays 0.

Source files
------------

// File: rtl/arb_req_client_pkg.sv
// Shared constants and helpers for the four-channel arbitrated request client.
// Grant vectors are one-hot per channel; all-zero means the arbiter is idle.
package arb_req_client_pkg;

   localparam int NCH = 4;
   localparam int CHW = 2;

   typedef logic [NCH-1:0] gnt_t;
   typedef logic [CHW-1:0] ch_t;

   localparam gnt_t GNT_NONE = 4'b0000;
   localparam gnt_t GNT_CH0  = 4'b0001;
   localparam gnt_t GNT_CH1  = 4'b0010;
   localparam gnt_t GNT_CH2  = 4'b0100;
   localparam gnt_t GNT_CH3  = 4'b1000;

   // True for a zero or single-bit grant vector.
   function automatic logic onehot0(input gnt_t g);
      return (g & (g - gnt_t'(1))) == GNT_NONE;
   endfunction

   function automatic ch_t gnt_index(input gnt_t g);
      ch_t idx;
      case (g)
         GNT_CH1: idx = ch_t'(1);
         GNT_CH2: idx = ch_t'(2);
         GNT_CH3: idx = ch_t'(3);
         default: idx = ch_t'(0);
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Single-channel queue: power-of-two depth, wrapping pointers, occupancy count.
// Storage is not reset; only pointers and count are, which empties the queue.
module arb_req_fifo
   import arb_req_client_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] rd_data,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Push and pop together leave the occupancy unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/arb_req_client.sv
// Four queued channels feeding a single output register through an external
// round-robin arbiter; flags grants that are malformed or not requested.
module arb_req_client
   import arb_req_client_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_valid,
   input  logic [CHW-1:0] wr_ch,
   input  logic [DW-1:0]  wr_data,
   output logic           wr_ready,
   output logic [NCH-1:0] req,
   input  logic [NCH-1:0] grant,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [CHW-1:0] out_ch,
   output logic [DW-1:0]  out_data,
   output logic           err,
   input  logic           err_clr
);

   localparam int AW = $clog2(DEPTH);

   logic [NCH-1:0] q_push;
   logic [NCH-1:0] q_pop;
   logic [NCH-1:0] q_full;
   logic [NCH-1:0] q_empty;
   logic [DW-1:0]  q_rd_data [NCH];
   logic [AW:0]    q_count   [NCH];

   logic           load_ok;
   logic [NCH-1:0] gnt_live;
   logic           pop_en;
   ch_t            gnt_ch;
   logic [NCH-1:0] req_q;
   logic           err_evt;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      arb_req_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push    (q_push[i]),
         .pop     (q_pop[i]),
         .wr_data (wr_data),
         .rd_data (q_rd_data[i]),
         .count   (q_count[i]),
         .full    (q_full[i]),
         .empty   (q_empty[i])
      );
   end

   assign wr_ready = !q_full[wr_ch];

   always_comb begin
      q_push = '0;
      for (int i = 0; i < NCH; i++) begin
         if (wr_valid && wr_ready && (wr_ch == CHW'(i))) begin
            q_push[i] = 1'b1;
         end
      end
   end

   always_comb begin
      req = '0;
      for (int i = 0; i < NCH; i++) begin
         req[i] = (q_count[i] != '0);
      end
   end

   // A grant only pops when it names exactly one non-empty channel and the
   // output register can take a beat; lag grants to empty channels fall out here.
   assign load_ok  = !out_valid || out_ready;
   assign gnt_live = grant & ~q_empty;
   assign pop_en   = onehot0(grant) && (gnt_live != '0) && load_ok;
   assign q_pop    = pop_en ? gnt_live : '0;
   assign gnt_ch   = gnt_index(grant);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
      end else if (pop_en) begin
         out_valid <= 1'b1;
         out_ch    <= gnt_ch;
         out_data  <= q_rd_data[gnt_ch];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // The arbiter is registered, so a legal grant always follows a request
   // seen in the previous cycle.
   assign err_evt = !onehot0(grant) || ((grant & ~req_q) != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q <= '0;
         err   <= 1'b0;
      end else begin
         req_q <= req;
         if (err_evt) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_req_client.sv
// Scoreboard bench for arb_req_client: queue-based reference model, bench-side
// round-robin arbiter, directed scenarios followed by randomized traffic.
module tb_arb_req_client;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0]    ch;
      logic [DW-1:0] d;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_valid = 1'b0;
   logic [1:0]    wr_ch = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready;
   logic [3:0]    req;
   logic [3:0]    grant = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    out_ch;
   logic [DW-1:0] out_data;
   logic          err;
   logic          err_clr = 1'b0;

   always #5 clk = ~clk;

   arb_req_client #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ch     (wr_ch),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .req       (req),
      .grant     (grant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .err       (err),
      .err_clr   (err_clr)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   logic [DW-1:0] mq [4][$];
   beat_t         exp_q[$];
   bit            mv;
   bit            err_m;
   logic [3:0]    req_prev;
   logic [3:0]    grant_next;
   int            rr_ptr;
   bit            arb_en;
   logic [3:0]    force_gnt;

   int            cyc_n = 0;
   int            hs_cnt = 0;
   bit            rec_on = 1'b0;
   int            obs_ch[$];
   int            obs_cyc[$];
   beat_t         mb;

   always @(posedge clk) cyc_n++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_req();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
      return r;
   endfunction

   // One clock cycle: apply inputs at the falling edge, compare settled
   // outputs, then advance the model across the coming rising edge.
   task automatic step(input bit wv, input logic [1:0] wch, input logic [DW-1:0] wd,
                       input bit ordy, input bit clr, output bit acc);
      logic [3:0] rq;
      logic [3:0] g;
      bit         load_ok;
      bit         evt;
      bit         popped;
      int         ch;
      beat_t      b;
      @(negedge clk);
      grant     = arb_en ? grant_next : force_gnt;
      wr_valid  = wv;
      wr_ch     = wch;
      wr_data   = wd;
      out_ready = ordy;
      err_clr   = clr;
      #1;
      rq = model_req();
      check("req", 32'(req), 32'(rq));
      check("wr_ready", 32'(wr_ready), 32'(mq[wch].size() < DEPTH));
      check("out_valid", 32'(out_valid), 32'(mv));
      check("err", 32'(err), 32'(err_m));

      acc     = wv && (mq[wch].size() < DEPTH);
      load_ok = !mv || ordy;
      g       = grant;
      evt     = ($countones(g) > 1) || ((g & ~req_prev) != 4'b0000);
      popped  = 1'b0;
      if ($countones(g) == 1) begin
         ch = 0;
         for (int i = 0; i < 4; i++) if (g[i]) ch = i;
         if (mq[ch].size() != 0 && load_ok) begin
            b.ch = 2'(ch);
            b.d  = mq[ch].pop_front();
            exp_q.push_back(b);
            mv     = 1'b1;
            popped = 1'b1;
         end
      end
      if (!popped && mv && ordy) mv = 1'b0;
      if (acc) mq[wch].push_back(wd);
      if (evt) err_m = 1'b1;
      else if (clr) err_m = 1'b0;
      req_prev   = rq;
      grant_next = 4'b0000;
      if (arb_en) begin
         for (int k = 0; k < 4; k++) begin
            int c;
            c = (rr_ptr + k) % 4;
            if (rq[c] && grant_next == 4'b0000) begin
               grant_next[c] = 1'b1;
               rr_ptr        = (c + 1) % 4;
            end
         end
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, ordy, 1'b0, acc);
   endtask

   task automatic push(input logic [1:0] ch, input logic [DW-1:0] d, input bit ordy);
      bit acc;
      step(1'b1, ch, d, ordy, 1'b0, acc);
      check("push_acc", 32'(acc), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      grant    = 4'b0000;
      wr_valid = 1'b0;
      wr_ch    = 2'd3;
      out_ready = 1'b0;
      err_clr  = 1'b0;
      for (int i = 0; i < 4; i++) mq[i].delete();
      exp_q.delete();
      mv = 1'b0; err_m = 1'b0; req_prev = '0; grant_next = '0; rr_ptr = 0;
      force_gnt = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_req", 32'(req), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_wr_ready", 32'(wr_ready), 32'h1);
   endtask

   // Monitor: every accepted beat must match the oldest expected beat.
   always @(negedge clk) begin
      #2;
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("beat_unexpected", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            mb = exp_q.pop_front();
            check("beat_ch", 32'(out_ch), 32'(mb.ch));
            check("beat_data", 32'(out_data), 32'(mb.d));
         end
         hs_cnt++;
         if (rec_on) begin
            obs_ch.push_back(int'(out_ch));
            obs_cyc.push_back(cyc_n);
         end
      end
   end

   initial begin
      bit acc;
      int hs0;
      arb_en = 1'b1;
      do_reset();

      // Reset mid-stream with three entries queued
      arb_en = 1'b0;
      push(2'd0, 8'h21, 1'b1);
      push(2'd1, 8'h22, 1'b1);
      push(2'd2, 8'h23, 1'b1);
      idle(1, 1'b1);
      check("pre_rst_req", 32'(req), 32'h7);
      do_reset();
      arb_en = 1'b1;
      idle(3, 1'b1);

      // Single entry, idle arbiter: two-edge latency
      push(2'd2, 8'h5A, 1'b1);
      idle(1, 1'b1);
      check("single_req", 32'(req), 32'h4);
      check("single_ov0", 32'(out_valid), 32'h0);
      idle(1, 1'b1);
      check("single_ov1", 32'(out_valid), 32'h0);
      idle(1, 1'b1);
      check("single_ov2", 32'(out_valid), 32'h1);
      check("single_ch", 32'(out_ch), 32'h2);
      check("single_data", 32'(out_data), 32'h5A);
      check("single_req_clr", 32'(req), 32'h0);
      idle(3, 1'b1);

      // Round robin: one entry per channel, arbiter released together
      do_reset();
      arb_en = 1'b0;
      for (int i = 0; i < 4; i++) push(2'(i), 8'(8'h10 + i), 1'b1);
      arb_en = 1'b1;
      obs_ch.delete();
      obs_cyc.delete();
      rec_on = 1'b1;
      idle(9, 1'b1);
      rec_on = 1'b0;
      check("rr_count", 32'(obs_ch.size()), 32'd4);
      if (obs_ch.size() == 4) begin
         for (int i = 0; i < 4; i++) check("rr_order", 32'(obs_ch[i]), 32'(i));
         for (int i = 1; i < 4; i++) check("rr_spacing", 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd1);
      end
      check("rr_err", 32'(err), 32'h0);

      // Backpressure: ch1 with two entries, consumer stalled
      do_reset();
      arb_en = 1'b1;
      push(2'd1, 8'hA1, 1'b0);
      push(2'd1, 8'hA2, 1'b0);
      idle(5, 1'b0);
      check("bp_out_valid", 32'(out_valid), 32'h1);
      check("bp_out_data", 32'(out_data), 32'hA1);
      check("bp_req1", 32'(req), 32'h2);
      hs0 = hs_cnt;
      idle(6, 1'b1);
      check("bp_beats", 32'(hs_cnt - hs0), 32'd2);

      // Full queue: fifth write held off until a pop frees a slot
      do_reset();
      arb_en = 1'b0;
      for (int i = 0; i < 4; i++) push(2'd3, 8'(8'hC0 + i), 1'b1);
      step(1'b1, 2'd3, 8'hC4, 1'b1, 1'b0, acc);
      check("full_wr_ready", 32'(wr_ready), 32'h0);
      check("full_acc", 32'(acc), 32'h0);
      arb_en = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 8 && !acc; i++) step(1'b1, 2'd3, 8'hC4, 1'b1, 1'b0, acc);
      check("full_accept", 32'(acc), 32'h1);
      idle(12, 1'b1);
      check("full_drained", 32'(req), 32'h0);

      // Protocol errors, sticky flag, clear, and the same-cycle priority
      do_reset();
      arb_en = 1'b0;
      force_gnt = 4'b0011;
      idle(1, 1'b1);
      force_gnt = 4'b0000;
      idle(1, 1'b1);
      check("err_multi", 32'(err), 32'h1);
      step(1'b0, 2'd0, '0, 1'b1, 1'b1, acc);
      idle(1, 1'b1);
      check("err_clr", 32'(err), 32'h0);
      force_gnt = 4'b0001;
      idle(1, 1'b1);
      force_gnt = 4'b0000;
      idle(3, 1'b1);
      check("err_unreq", 32'(err), 32'h1);
      force_gnt = 4'b0010;
      step(1'b0, 2'd0, '0, 1'b1, 1'b1, acc);
      force_gnt = 4'b0000;
      idle(1, 1'b1);
      check("err_clr_lose", 32'(err), 32'h1);
      step(1'b0, 2'd0, '0, 1'b1, 1'b1, acc);
      idle(1, 1'b1);
      check("err_clr2", 32'(err), 32'h0);
      arb_en = 1'b1;
      push(2'd0, 8'h77, 1'b1);
      idle(6, 1'b1);
      check("err_lag", 32'(err), 32'h0);

      // Randomized traffic against the model
      do_reset();
      arb_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 8'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), acc);
      end
      idle(40, 1'b1);
      check("rand_exp_empty", 32'(exp_q.size()), 32'd0);
      check("rand_req_empty", 32'(req), 32'h0);
      check("rand_err", 32'(err), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
